// File: rtl/instr_fetch_issue_if.sv
// Fetch/issue stage bus: instruction memory, control-unit PC select and
// redirect targets on the way in; PC, pipeline registers and issue count out.
interface instr_fetch_issue_if #(
    parameter int PC_WIDTH = 32
);
    logic [31:0]         InstrIn;
    logic                Stall;
    logic [1:0]          MuxDireccionPC;
    logic [PC_WIDTH-1:0] JumpTarget;
    logic [PC_WIDTH-1:0] BranchTarget;
    logic [PC_WIDTH-1:0] PC;
    logic [31:0]         InstrIFID;
    logic [4:0]          Opcode;
    logic [4:0]          OpCodeIDEXOUT;
    logic [31:0]         IssueCount;

    // Driver side: memory model / control unit
    modport master (
        output InstrIn, Stall, MuxDireccionPC, JumpTarget, BranchTarget,
        input  PC, InstrIFID, Opcode, OpCodeIDEXOUT, IssueCount
    );

    // Fetch/issue stage side
    modport slave (
        input  InstrIn, Stall, MuxDireccionPC, JumpTarget, BranchTarget,
        output PC, InstrIFID, Opcode, OpCodeIDEXOUT, IssueCount
    );
endinterface

// File: rtl/instr_fetch_issue.sv
// Instruction fetch and issue stage: PC register, IF/ID instruction register,
// ID/EX opcode register and bubble insertion for jumps and conditional branches.
// A conditional branch in ID parks the stage in BR_WAIT for one unstalled cycle
// while the control unit resolves it from ID/EX.
module instr_fetch_issue #(
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = {PC_WIDTH{1'b0}},
    parameter logic [4:0]          NOP_OPCODE = 5'b10111
) (
    input  logic clk,
    input  logic reset,
    instr_fetch_issue_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } state_t;

    localparam logic [31:0]         BUBBLE_WORD = {NOP_OPCODE, 27'd0};
    localparam logic [PC_WIDTH-1:0] PC_ONE      = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [31:0]         ISSUE_ONE   = 32'd1;
    localparam logic [1:0]          SEL_JUMP    = 2'b01;
    localparam logic [1:0]          SEL_TAKEN   = 2'b10;

    // Conditional branch opcodes that must be resolved from ID/EX
    function automatic logic is_cond_branch(input logic [4:0] op);
        return (op == 5'b10100) || (op == 5'b10101);
    endfunction

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_ifid_q, instr_ifid_d;
    logic [4:0]          opcode_idex_q, opcode_idex_d;
    logic [31:0]         issue_cnt_q, issue_cnt_d;
    logic [4:0]          opcode_s;

    assign opcode_s = instr_ifid_q[31:27];

    // Next-state logic: PC select, bubble insertion and issue counting
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_ifid_d  = instr_ifid_q;
        opcode_idex_d = opcode_idex_q;
        issue_cnt_d   = issue_cnt_q;
        if (bus.Stall) begin
            // Whole stage frozen; select deliberately ignored
            state_d = state_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    opcode_idex_d = opcode_s;
                    if (is_cond_branch(opcode_s)) begin
                        // Branch wins over any select: hold PC, kill the fetch
                        pc_d         = pc_q;
                        instr_ifid_d = BUBBLE_WORD;
                        state_d      = ST_BR_WAIT;
                    end else begin
                        case (bus.MuxDireccionPC)
                            SEL_JUMP: begin
                                pc_d         = bus.JumpTarget;
                                instr_ifid_d = BUBBLE_WORD;
                            end
                            default: begin
                                pc_d         = pc_q + PC_ONE;
                                instr_ifid_d = bus.InstrIn;
                            end
                        endcase
                        state_d = ST_RUN;
                    end
                end
                ST_BR_WAIT: begin
                    opcode_idex_d = NOP_OPCODE;
                    if (bus.MuxDireccionPC == SEL_TAKEN) begin
                        pc_d         = bus.BranchTarget;
                        instr_ifid_d = BUBBLE_WORD;
                    end else begin
                        // Fall-through word at branch+1 is already on InstrIn
                        pc_d         = pc_q + PC_ONE;
                        instr_ifid_d = bus.InstrIn;
                    end
                    state_d = ST_RUN;
                end
                default: begin
                    // Unreachable encoding: flush to a clean RUN state
                    pc_d          = pc_q;
                    instr_ifid_d  = BUBBLE_WORD;
                    opcode_idex_d = NOP_OPCODE;
                    state_d       = ST_RUN;
                end
            endcase
            if (opcode_idex_d != NOP_OPCODE) begin
                issue_cnt_d = issue_cnt_q + ISSUE_ONE;
            end else begin
                issue_cnt_d = issue_cnt_q;
            end
        end
    end

    // State register: synchronous reset has priority over stall and select
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            instr_ifid_q  <= BUBBLE_WORD;
            opcode_idex_q <= NOP_OPCODE;
            issue_cnt_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_ifid_q  <= instr_ifid_d;
            opcode_idex_q <= opcode_idex_d;
            issue_cnt_q   <= issue_cnt_d;
        end
    end

    assign bus.PC            = pc_q;
    assign bus.InstrIFID     = instr_ifid_q;
    assign bus.Opcode        = opcode_s;
    assign bus.OpCodeIDEXOUT = opcode_idex_q;
    assign bus.IssueCount    = issue_cnt_q;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Directed bench for instr_fetch_issue: sequential fetch, jump, taken and
// not-taken branches, stall in BR_WAIT, reset mid-branch and PC wrap.
module tb_instr_fetch_issue;

    localparam logic [31:0] OP_NOP = 32'h0000_0017;
    localparam logic [31:0] BUBBLE = 32'hB800_0000;

    logic clk;
    logic reset;
    logic [31:0] imem [0:255];
    int total;
    int passed;

    instr_fetch_issue_if #(.PC_WIDTH(32)) bus ();

    instr_fetch_issue #(
        .PC_WIDTH   (32),
        .RESET_PC   (32'd0),
        .NOP_OPCODE (5'b10111)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.InstrIn = imem[bus.PC[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [4:0] op, input logic [26:0] tag);
        return {op, tag};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.Stall = 1'b0;
        bus.MuxDireccionPC = 2'b00;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] op32(input logic [4:0] op);
        return {27'd0, op};
    endfunction

    initial begin
        total = 0;
        passed = 0;
        for (int i = 0; i < 256; i++) imem[i] = {5'b00000, 27'(i)};
        reset = 1'b1;
        bus.Stall = 1'b0;
        bus.MuxDireccionPC = 2'b00;
        bus.JumpTarget = 32'd0;
        bus.BranchTarget = 32'd0;

        // Reset state and sequential fetch
        do_reset();
        reset = 1'b1;
        step();
        chk("rst_pc", bus.PC, 32'd0);
        chk("rst_ifid", bus.InstrIFID, BUBBLE);
        chk("rst_op", op32(bus.Opcode), OP_NOP);
        chk("rst_opex", op32(bus.OpCodeIDEXOUT), OP_NOP);
        chk("rst_cnt", bus.IssueCount, 32'd0);
        reset = 1'b0;
        step();
        chk("seq_pc1", bus.PC, 32'd1);
        chk("seq_op1", op32(bus.Opcode), 32'd0);
        step();
        chk("seq_pc2", bus.PC, 32'd2);
        chk("seq_opex2", op32(bus.OpCodeIDEXOUT), 32'd0);
        step();
        step();
        chk("seq_pc4", bus.PC, 32'd4);
        chk("seq_cnt", bus.IssueCount, 32'd3);

        // Jump at address 2 to 0x40; word at 3 must never issue
        imem[2] = w(5'b10011, 27'd2);
        imem[3] = w(5'b00011, 27'd3);
        do_reset();
        step(); step(); step();
        chk("jmp_op", op32(bus.Opcode), 32'h13);
        bus.MuxDireccionPC = 2'b01;
        bus.JumpTarget = 32'h40;
        step();
        chk("jmp_pc", bus.PC, 32'h40);
        chk("jmp_bubble", op32(bus.Opcode), OP_NOP);
        chk("jmp_opex", op32(bus.OpCodeIDEXOUT), 32'h13);
        bus.MuxDireccionPC = 2'b00;
        step();
        chk("jmp_pc1", bus.PC, 32'h41);
        chk("jmp_ifid", bus.InstrIFID, 32'h0000_0040);
        chk("jmp_opexnop", op32(bus.OpCodeIDEXOUT), OP_NOP);
        step();
        chk("jmp_opex_tgt", op32(bus.OpCodeIDEXOUT), 32'd0);
        chk("jmp_cnt", bus.IssueCount, 32'd4);
        imem[2] = w(5'b00000, 27'd2);
        imem[3] = w(5'b00000, 27'd3);

        // Branch taken at 5; jump select in the same cycle must lose
        imem[5] = w(5'b10101, 27'd5);
        do_reset();
        repeat (6) step();
        chk("bt_pc6", bus.PC, 32'd6);
        chk("bt_op", op32(bus.Opcode), 32'h15);
        bus.MuxDireccionPC = 2'b01;
        bus.JumpTarget = 32'h99;
        step();
        chk("bt_hold", bus.PC, 32'd6);
        chk("bt_opex", op32(bus.OpCodeIDEXOUT), 32'h15);
        chk("bt_ifid", bus.InstrIFID, BUBBLE);
        bus.MuxDireccionPC = 2'b10;
        bus.BranchTarget = 32'h20;
        step();
        chk("bt_pc_tgt", bus.PC, 32'h20);
        chk("bt_nop1", op32(bus.OpCodeIDEXOUT), OP_NOP);
        chk("bt_op_bub", op32(bus.Opcode), OP_NOP);
        bus.MuxDireccionPC = 2'b00;
        step();
        chk("bt_pc21", bus.PC, 32'h21);
        chk("bt_nop2", op32(bus.OpCodeIDEXOUT), OP_NOP);
        chk("bt_ifid_tgt", bus.InstrIFID, 32'h0000_0020);
        chk("bt_cnt", bus.IssueCount, 32'd6);

        // Branch not taken at 5: one bubble, then instruction 6 issues
        imem[5] = w(5'b10100, 27'd5);
        imem[6] = w(5'b00110, 27'd6);
        do_reset();
        repeat (7) step();
        chk("bn_hold", bus.PC, 32'd6);
        chk("bn_opex", op32(bus.OpCodeIDEXOUT), 32'h14);
        step();
        chk("bn_pc7", bus.PC, 32'd7);
        chk("bn_ifid", bus.InstrIFID, 32'h3000_0006);
        chk("bn_nop", op32(bus.OpCodeIDEXOUT), OP_NOP);
        step();
        chk("bn_pc8", bus.PC, 32'd8);
        chk("bn_issue6", op32(bus.OpCodeIDEXOUT), 32'h06);
        chk("bn_cnt", bus.IssueCount, 32'd7);

        // Stall for 3 cycles in BR_WAIT with a stray taken select
        do_reset();
        repeat (7) step();
        bus.Stall = 1'b1;
        bus.MuxDireccionPC = 2'b10;
        bus.BranchTarget = 32'h55;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("st_pc", bus.PC, 32'd6);
            chk("st_opex", op32(bus.OpCodeIDEXOUT), 32'h14);
        end
        chk("st_ifid", bus.InstrIFID, BUBBLE);
        chk("st_cnt", bus.IssueCount, 32'd6);
        bus.Stall = 1'b0;
        bus.BranchTarget = 32'h30;
        step();
        chk("st_pc_tgt", bus.PC, 32'h30);
        chk("st_nop", op32(bus.OpCodeIDEXOUT), OP_NOP);
        chk("st_cnt2", bus.IssueCount, 32'd6);
        bus.MuxDireccionPC = 2'b00;

        // Reset while in BR_WAIT, then PC wrap via jump to all-ones
        do_reset();
        repeat (7) step();
        bus.MuxDireccionPC = 2'b10;
        reset = 1'b1;
        step();
        chk("rb_pc", bus.PC, 32'd0);
        chk("rb_opex", op32(bus.OpCodeIDEXOUT), OP_NOP);
        chk("rb_cnt", bus.IssueCount, 32'd0);
        chk("rb_ifid", bus.InstrIFID, BUBBLE);
        reset = 1'b0;
        bus.MuxDireccionPC = 2'b00;
        step();
        chk("rb_run_pc", bus.PC, 32'd1);
        chk("rb_run_ifid", bus.InstrIFID, 32'd0);
        bus.MuxDireccionPC = 2'b01;
        bus.JumpTarget = 32'hFFFF_FFFF;
        step();
        chk("wrap_max", bus.PC, 32'hFFFF_FFFF);
        bus.MuxDireccionPC = 2'b00;
        step();
        chk("wrap_zero", bus.PC, 32'd0);
        chk("wrap_ifid", bus.InstrIFID, 32'h0000_00FF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
